// File: rtl/smul_result_wb.sv
// smul_result_wb: writeback stage behind the 16-lane FP16 scalar-vector multiplier.
// Buffers product vectors in a DEPTH-entry FIFO and drains each one to the vector
// register file write port as BEATS beats of WB_W bits, low lanes first.
// Optional build macro: SMUL_WB_INFCNT_EN adds inf_count (Inf/NaN lanes of the last
// completed vector).
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   in_valid/in_ready/in_prod/in_ovf/in_dst
//                                  product vector handshake from the multiplier
//   wb_en/wb_addr/wb_beat/wb_data  write beat to the register file
//   wb_ack                         register file accepted the current beat
//   busy                           FIFO non-empty or write in progress
//   ovf_sticky/ovf_clr             sticky overflow status and its clear
//   inf_count                      (SMUL_WB_INFCNT_EN only) Inf/NaN lane count
module smul_result_wb #(
   parameter int unsigned DEPTH  = 2,
   parameter int unsigned WB_W   = 64,
   parameter int unsigned REG_AW = 3,
   localparam int unsigned BEATS = 256 / WB_W,
   localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [255:0]      in_prod,
   input  logic              in_ovf,
   input  logic [REG_AW-1:0] in_dst,
   output logic              wb_en,
   output logic [REG_AW-1:0] wb_addr,
   output logic [BW-1:0]     wb_beat,
   output logic [WB_W-1:0]   wb_data,
   input  logic              wb_ack,
   output logic              busy,
   output logic              ovf_sticky,
   input  logic              ovf_clr
`ifdef SMUL_WB_INFCNT_EN
  ,output logic [4:0]        inf_count
`endif
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

   typedef enum logic {IDLE = 1'b0, WRITE = 1'b1} state_t;

   state_t            state, state_nxt;
   logic [BW-1:0]     beat, beat_nxt;
   logic [PW-1:0]     wr_ptr, rd_ptr, rd_ptr_nxt;
   logic [CW-1:0]     count, cnt_after_pop, count_nxt;
   logic              push, pop, bypass;
   logic [255:0]      head_prod_nxt;
   logic [REG_AW-1:0] head_dst_nxt;
   logic [WB_W-1:0]   wb_data_nxt;

   // Overflow is folded into ovf_sticky at push time, so only data and dst are stored.
   logic [255:0]      prod_mem [DEPTH];
   logic [REG_AW-1:0] dst_mem  [DEPTH];

   assign push    = in_valid & in_ready;
   assign wb_beat = beat;

   // FIFO storage
   always_ff @(posedge clk) begin
      if (push) begin
         prod_mem[wr_ptr] <= in_prod;
         dst_mem[wr_ptr]  <= in_dst;
      end
   end

   // Next state, FIFO bookkeeping and next head selection
   always_comb begin
      state_nxt = state;
      beat_nxt  = beat;
      pop       = 1'b0;
      unique case (state)
         IDLE: begin
            if (count != '0) begin
               state_nxt = WRITE;
               beat_nxt  = '0;
            end
         end
         WRITE: begin
            if (wb_ack) begin
               if (beat == LAST_BEAT) begin
                  pop      = 1'b1;
                  beat_nxt = '0;
               end else begin
                  beat_nxt = beat + BW'(1);
               end
            end
         end
      endcase
      cnt_after_pop = count - CW'(pop);
      count_nxt     = cnt_after_pop + CW'(push);
      if (pop && (count_nxt == '0)) state_nxt = IDLE;
      rd_ptr_nxt = rd_ptr + PW'(pop);
      // A vector pushed into an otherwise empty FIFO is not in storage yet; take it from the input.
      bypass        = push && (cnt_after_pop == '0);
      head_prod_nxt = bypass ? in_prod : prod_mem[rd_ptr_nxt];
      head_dst_nxt  = bypass ? in_dst  : dst_mem[rd_ptr_nxt];
      wb_data_nxt   = head_prod_nxt[int'(beat_nxt) * WB_W +: WB_W];
   end

   // State, pointers and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         beat       <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         in_ready   <= 1'b1;
         wb_en      <= 1'b0;
         wb_addr    <= '0;
         wb_data    <= '0;
         busy       <= 1'b0;
         ovf_sticky <= 1'b0;
      end else begin
         state    <= state_nxt;
         beat     <= beat_nxt;
         rd_ptr   <= rd_ptr_nxt;
         count    <= count_nxt;
         if (push) wr_ptr <= wr_ptr + PW'(1);
         in_ready <= (count_nxt < CW'(DEPTH));
         wb_en    <= (state_nxt == WRITE);
         if (state_nxt == WRITE) begin
            wb_addr <= head_dst_nxt;
            wb_data <= wb_data_nxt;
         end else begin
            wb_addr <= '0;
            wb_data <= '0;
         end
         busy <= (count_nxt != '0) || (state_nxt == WRITE);
         // Set has priority over clear.
         if (push && in_ovf) ovf_sticky <= 1'b1;
         else if (ovf_clr)   ovf_sticky <= 1'b0;
      end
   end

`ifdef SMUL_WB_INFCNT_EN
   logic [4:0] inf_nxt;

   // Count head lanes whose exponent field is all ones (Inf or NaN)
   always_comb begin
      inf_nxt = '0;
      for (int i = 0; i < 16; i++) begin
         inf_nxt = inf_nxt + 5'(prod_mem[rd_ptr][16*i+10 +: 5] == 5'h1F);
      end
   end

   // Loaded when the head vector completes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   inf_count <= '0;
      else if (pop) inf_count <= inf_nxt;
   end
`endif

endmodule

// File: tb/tb_smul_result_wb.sv
// Directed bench for smul_result_wb (DEPTH=2, WB_W=64, REG_AW=3).
module tb_smul_result_wb;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [255:0] in_prod = '0;
   logic         in_ovf = 1'b0;
   logic [2:0]   in_dst = '0;
   logic         wb_en;
   logic [2:0]   wb_addr;
   logic [1:0]   wb_beat;
   logic [63:0]  wb_data;
   logic         wb_ack = 1'b0;
   logic         busy;
   logic         ovf_sticky;
   logic         ovf_clr = 1'b0;
`ifdef SMUL_WB_INFCNT_EN
   logic [4:0]   inf_count;
`endif

   smul_result_wb #(.DEPTH(2), .WB_W(64), .REG_AW(3)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_prod(in_prod),
      .in_ovf(in_ovf), .in_dst(in_dst),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_beat(wb_beat), .wb_data(wb_data),
      .wb_ack(wb_ack), .busy(busy), .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr)
`ifdef SMUL_WB_INFCNT_EN
     ,.inf_count(inf_count)
`endif
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic [2:0]  dst;
      logic [15:0] base;
      logic [63:0] b0;
      logic [63:0] b3;
      logic [4:0]  inf;
   } vec_t;

   vec_t tbl [4];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [255:0] mk_vec(input logic [15:0] base);
      logic [255:0] v;
      for (int i = 0; i < 16; i++) v[16*i +: 16] = base + 16'(i);
      return v;
   endfunction

   function automatic logic [63:0] exp_beat(input logic [15:0] base, input int b);
      logic [63:0] r;
      for (int k = 0; k < 4; k++) r[16*k +: 16] = base + 16'(4*b + k);
      return r;
   endfunction

   task automatic drain();
      wb_ack   = 1'b1;
      in_valid = 1'b0;
      for (int i = 0; i < 40 && busy; i++) step();
      chk("drain_busy", 64'(busy), 64'd0);
   endtask

   initial begin
      logic [255:0] v;
      logic [63:0]  want;

      tbl[0] = '{3'd5, 16'h3C00, 64'h3C03_3C02_3C01_3C00, 64'h3C0F_3C0E_3C0D_3C0C, 5'd0};
      tbl[1] = '{3'd0, 16'h0000, 64'h0003_0002_0001_0000, 64'h000F_000E_000D_000C, 5'd0};
      tbl[2] = '{3'd7, 16'hFFF0, 64'hFFF3_FFF2_FFF1_FFF0, 64'hFFFF_FFFE_FFFD_FFFC, 5'd16};
      tbl[3] = '{3'd2, 16'h7BF8, 64'h7BFB_7BFA_7BF9_7BF8, 64'h7C07_7C06_7C05_7C04, 5'd8};

      // Reset values
      step(); step();
      rst_n = 1'b1;
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_wb_en", 64'(wb_en), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_ovf", 64'(ovf_sticky), 64'd0);
      chk("rst_wb_addr", 64'(wb_addr), 64'd0);
      chk("rst_wb_beat", 64'(wb_beat), 64'd0);
      chk("rst_wb_data", wb_data, 64'd0);
`ifdef SMUL_WB_INFCNT_EN
      chk("rst_inf", 64'(inf_count), 64'd0);
`endif
      step();
      chk("idle_wb_en", 64'(wb_en), 64'd0);

      // Single vectors with continuous ack
      foreach (tbl[t]) begin
         in_valid = 1'b1;
         in_prod  = mk_vec(tbl[t].base);
         in_dst   = tbl[t].dst;
         in_ovf   = 1'b0;
         wb_ack   = 1'b1;
         step();
         in_valid = 1'b0;
         chk($sformatf("v%0d_lat_en", t), 64'(wb_en), 64'd0);
         chk($sformatf("v%0d_lat_busy", t), 64'(busy), 64'd1);
         for (int b = 0; b < 4; b++) begin
            step();
            want = (b == 0) ? tbl[t].b0 : (b == 3) ? tbl[t].b3 : exp_beat(tbl[t].base, b);
            chk($sformatf("v%0d_b%0d_en", t, b), 64'(wb_en), 64'd1);
            chk($sformatf("v%0d_b%0d_beat", t, b), 64'(wb_beat), 64'(b));
            chk($sformatf("v%0d_b%0d_addr", t, b), 64'(wb_addr), 64'(tbl[t].dst));
            chk($sformatf("v%0d_b%0d_data", t, b), wb_data, want);
         end
         step();
         chk($sformatf("v%0d_end_en", t), 64'(wb_en), 64'd0);
         chk($sformatf("v%0d_end_busy", t), 64'(busy), 64'd0);
`ifdef SMUL_WB_INFCNT_EN
         chk($sformatf("v%0d_inf", t), 64'(inf_count), 64'(tbl[t].inf));
`endif
      end
      chk("no_ovf_yet", 64'(ovf_sticky), 64'd0);

      // Backpressure at beat 1
      wb_ack   = 1'b0;
      in_valid = 1'b1;
      in_prod  = mk_vec(16'h5000);
      in_dst   = 3'd4;
      step();
      in_valid = 1'b0;
      step();
      chk("bp_b0_data", wb_data, exp_beat(16'h5000, 0));
      wb_ack = 1'b1;
      step();
      wb_ack = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk($sformatf("bp_hold%0d_beat", i), 64'(wb_beat), 64'd1);
         chk($sformatf("bp_hold%0d_data", i), wb_data, exp_beat(16'h5000, 1));
         chk($sformatf("bp_hold%0d_en", i), 64'(wb_en), 64'd1);
      end
      wb_ack = 1'b1;
      step();
      chk("bp_adv_beat", 64'(wb_beat), 64'd2);
      chk("bp_adv_data", wb_data, exp_beat(16'h5000, 2));
      drain();

      // FIFO full and back-to-back drain
      wb_ack   = 1'b0;
      in_valid = 1'b1;
      in_prod  = mk_vec(16'h1000);
      in_dst   = 3'd1;
      step();
      chk("full_rdy_after1", 64'(in_ready), 64'd1);
      in_prod = mk_vec(16'h2000);
      in_dst  = 3'd2;
      step();
      chk("full_rdy_after2", 64'(in_ready), 64'd0);
      in_prod = mk_vec(16'h3000);
      in_dst  = 3'd3;
      step();
      chk("full_rdy_held", 64'(in_ready), 64'd0);
      chk("full_v1_addr", 64'(wb_addr), 64'd1);
      chk("full_v1_beat", 64'(wb_beat), 64'd0);
      wb_ack = 1'b1;
      step(); step(); step();
      chk("full_v1_b3_beat", 64'(wb_beat), 64'd3);
      chk("full_v1_b3_data", wb_data, exp_beat(16'h1000, 3));
      step();
      chk("full_rdy_after_pop", 64'(in_ready), 64'd1);
      chk("full_v2_en", 64'(wb_en), 64'd1);
      chk("full_v2_beat", 64'(wb_beat), 64'd0);
      chk("full_v2_addr", 64'(wb_addr), 64'd2);
      chk("full_v2_data", wb_data, exp_beat(16'h2000, 0));
      step();
      in_valid = 1'b0;
      chk("full_v2_b1_beat", 64'(wb_beat), 64'd1);
      step(); step(); step();
      chk("full_v3_en", 64'(wb_en), 64'd1);
      chk("full_v3_addr", 64'(wb_addr), 64'd3);
      chk("full_v3_data", wb_data, exp_beat(16'h3000, 0));
      drain();

      // Sticky overflow
      wb_ack   = 1'b1;
      in_valid = 1'b1;
      in_ovf   = 1'b1;
      in_prod  = mk_vec(16'h4000);
      in_dst   = 3'd6;
      step();
      chk("ovf_set", 64'(ovf_sticky), 64'd1);
      ovf_clr = 1'b1;
      step();
      chk("ovf_set_wins", 64'(ovf_sticky), 64'd1);
      in_valid = 1'b0;
      in_ovf   = 1'b0;
      step();
      chk("ovf_clr", 64'(ovf_sticky), 64'd0);
      ovf_clr = 1'b0;
      drain();

`ifdef SMUL_WB_INFCNT_EN
      // Inf/NaN lane count
      v = mk_vec(16'h3C00);
      v[16*3 +: 16] = 16'h7C00;
      v[16*9 +: 16] = 16'h7C00;
      v[16*4 +: 16] = 16'hFE00;
      in_valid = 1'b1;
      in_prod  = v;
      in_dst   = 3'd1;
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 5; i++) step();
      chk("inf_count3", 64'(inf_count), 64'd3);
      drain();
`else
      v = '0;
`endif

      // Reset in the middle of a write
      wb_ack   = 1'b0;
      in_valid = 1'b1;
      in_ovf   = 1'b1;
      in_prod  = mk_vec(16'h6000);
      in_dst   = 3'd3;
      step();
      in_valid = 1'b0;
      in_ovf   = 1'b0;
      step();
      chk("mid_wb_en", 64'(wb_en), 64'd1);
      chk("mid_ovf", 64'(ovf_sticky), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("mrst_wb_en", 64'(wb_en), 64'd0);
      chk("mrst_busy", 64'(busy), 64'd0);
      chk("mrst_in_ready", 64'(in_ready), 64'd1);
      chk("mrst_ovf", 64'(ovf_sticky), 64'd0);
      step();
      rst_n  = 1'b1;
      wb_ack = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         chk($sformatf("post_rst%0d_en", i), 64'(wb_en), 64'd0);
      end
      chk("post_rst_busy", 64'(busy), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
